mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- CPU-side initiator for the single-port, byte-addressed data memory.
- Accepts one load/store request at a time from the pipeline MEM stage and sequences the memory read/write strobes.
- Sub-word stores are done as read-modify-write, because the memory port always writes 4 consecutive bytes.
- Load results are sign- or zero-extended; the pipeline is stalled via busy_o until the access completes.

Parameters:
- RD_LAT, 1: memory read latency in cycles. Legal range 1..3; the memory's registered read data is valid RD_LAT cycles after mem_rd_o is first driven.

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  asynchronous, active-low reset
- req_i  in  1  request strobe, sampled only in IDLE
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- addr_i  in  32  byte address
- wdata_i  in  32  store data; the low bytes are used for sub-word stores
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle completion pulse, registered
- rdata_o  out  32  extended load result, registered; holds its value until the next load completes
- err_o  out  1  misalignment pulse; see Optional Feature
- mem_addr_o  out  32  address to the memory
- mem_wdata_o  out  32  write data to the memory
- mem_wr_o  out  1  memory write strobe
- mem_rd_o  out  1  memory read strobe
- mem_rdata_i  in  32  memory read data; byte 0 is at addr, byte 3 at addr+3

Behaviour:
- Reset (rst_i=0): takes effect immediately.
  - State goes to IDLE.
  - busy_o, done_o, err_o, mem_wr_o, mem_rd_o are 0.
  - rdata_o, mem_addr_o, mem_wdata_o are 0.
  - Latched request fields are cleared.
- States: IDLE, RD_WAIT, LD_CAP, ST_WR, RMW_WR.
- Accept (IDLE, req_i=1):
  - Latch we_i, size_i, unsigned_i, addr_i, wdata_i.
  - Word store goes to ST_WR.
  - Load or sub-word store goes to RD_WAIT with the wait counter set to RD_LAT-1.
- req_i is ignored outside IDLE, and no request is queued. The requester must hold the request until busy_o falls and done_o is seen.
- Latched address and data drive mem_addr_o and mem_wdata_o from the cycle after accept until return to IDLE. In IDLE they hold their last values.
- RD_WAIT:
  - mem_rd_o=1.
  - While counter != 0: decrement and stay.
  - At 0: a load goes to LD_CAP; a sub-word store goes to RMW_WR.
- LD_CAP:
  - mem_rd_o=0.
  - Extract byte [7:0] or half [15:0] (or the full word) from mem_rdata_i.
  - Extend per unsigned_i and register into rdata_o.
  - Set done_o=1 and go to IDLE.
- ST_WR:
  - mem_wr_o=1, mem_wdata_o=wdata.
  - Set done_o=1 and go to IDLE.
- RMW_WR:
  - mem_wr_o=1.
  - mem_wdata_o is mem_rdata_i with the low byte (byte store) or low two bytes (half store) replaced from wdata. The upper bytes are unchanged.
  - Set done_o=1 and go to IDLE.
- Latency from the accept cycle (cycle 0) to the done_o-high cycle:
  - Word store: 2.
  - Load: RD_LAT+2.
  - Sub-word store: RD_LAT+2.
- mem_wr_o and mem_rd_o are never high in the same cycle.
- Address wrap-around inside memory is the memory's concern; addr is passed through unmodified.
- Back-to-back: a new req_i in the IDLE cycle that follows done is accepted, giving one-request-per-(latency+1) throughput.
- Reset mid-operation: the access is abandoned, no done_o is produced, and mem_wr_o drops immediately. A partial RMW never writes.

Optional Feature:
- Macro MEM_ACC_ALIGN_CHK_EN.
- When defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, is rejected in IDLE.
  - No memory strobes are issued.
  - err_o=1 and done_o=1 in the next cycle; rdata_o is unchanged.
- When undefined: err_o is tied 0, and unaligned accesses proceed byte-contiguously as normal.

Test Plan:
- Word store then load, RD_LAT=1: store 0xDEADBEEF at 0x04; load word at 0x04 → done_o at cycle 2 for the store and cycle 3 for the load; rdata_o=0xDEADBEEF.
- Byte store RMW: mem[0x08..0x0B]=0x11223344; store byte wdata=0x000000AA at 0x08 → single mem_wr_o with mem_wdata_o=0x112233AA; word load returns 0x112233AA.
- Sign/zero extension: mem[0x10]=0x80; load byte signed → 0xFFFFFF80; unsigned → 0x00000080; half at 0x10 over 0xFFFF8001 (bytes 01,80) signed → 0xFFFF8001.
- Busy/ignore: hold req_i for 5 cycles with different addresses → exactly one access per accept; second accept occurs in the first IDLE cycle after done_o.
- Reset mid-RMW: assert rst_i low during RD_WAIT of a half store → mem_wr_o never asserted, memory contents unchanged, all outputs 0.
- MEM_ACC_ALIGN_CHK_EN: word load at 0x06 → err_o=done_o=1 one cycle later, no mem_rd_o; without the macro → normal load of bytes 0x06..0x09.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for a byte-addressed data memory; sub-word stores use read-modify-write.
// Optional misalignment rejection is compiled in with `define MEM_ACC_ALIGN_CHK_EN.
module mem_access_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_wr_o,
  output logic        mem_rd_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, LD_CAP, ST_WR, RMW_WR} state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t      state_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  cnt_q;
  logic        accept;
  logic        misalign;
  logic [31:0] ld_val;
  logic [31:0] rmw_val;

  // The done cycle is IDLE, but the requester is still holding req_i for the
  // request that just finished; ignoring it there avoids a duplicate access.
  assign accept = (state_q == IDLE) && req_i && !done_o;

`ifdef MEM_ACC_ALIGN_CHK_EN
  logic err_q;

  assign misalign = ((size_i == 2'b01) && addr_i[0]) ||
                    (size_i[1] && (addr_i[1:0] != 2'b00));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= accept && misalign;
  end

  assign err_o = err_q;
`else
  assign misalign = 1'b0;
  assign err_o    = 1'b0;
`endif

  assign busy_o     = (state_q != IDLE);
  assign mem_addr_o = addr_q;
  // Merge data is only valid while the memory presents the read word, so it
  // is driven combinationally during the write cycle instead of registered.
  assign mem_wdata_o = (state_q == RMW_WR) ? rmw_val : wdata_q;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ld_val  = mem_rdata_i;
    rmw_val = wdata_q;
    case (size_q)
      2'b00: begin
        ld_val  = {{24{~uns_q & mem_rdata_i[7]}}, mem_rdata_i[7:0]};
        rmw_val = {mem_rdata_i[31:8], wdata_q[7:0]};
      end
      2'b01: begin
        ld_val  = {{16{~uns_q & mem_rdata_i[15]}}, mem_rdata_i[15:0]};
        rmw_val = {mem_rdata_i[31:16], wdata_q[15:0]};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      done_o   <= 1'b0;
      rdata_o  <= '0;
      mem_wr_o <= 1'b0;
      mem_rd_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (misalign) begin
              done_o <= 1'b1;
            end else begin
              we_q    <= we_i;
              uns_q   <= unsigned_i;
              size_q  <= size_i;
              addr_q  <= addr_i;
              wdata_q <= wdata_i;
              if (we_i && size_i[1]) begin
                state_q  <= ST_WR;
                mem_wr_o <= 1'b1;
              end else begin
                state_q  <= RD_WAIT;
                mem_rd_o <= 1'b1;
                cnt_q    <= CNT_INIT;
              end
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            mem_rd_o <= 1'b0;
            if (we_q) begin
              state_q  <= RMW_WR;
              mem_wr_o <= 1'b1;
            end else begin
              state_q <= LD_CAP;
            end
          end
        end
        LD_CAP: begin
          rdata_o <= ld_val;
          done_o  <= 1'b1;
          state_q <= IDLE;
        end
        ST_WR, RMW_WR: begin
          mem_wr_o <= 1'b0;
          done_o   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (RD_LAT=1) with a 64-byte behavioural memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err_o;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, mem_rd;

  logic [7:0]  mem [0:63];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0, rd_starts = 0, overlap = 0;
  logic [31:0] last_wdata, last_waddr;
  logic        rd_prev = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.RD_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .busy_o(busy),
    .done_o(done), .rdata_o(rdata), .err_o(err_o), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wr_o(mem_wr), .mem_rd_o(mem_rd),
    .mem_rdata_i(mem_rdata)
  );

  // Registered-read memory: data appears one cycle after mem_rd is first seen.
  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr[5:0]]        = mem_wdata[7:0];
      mem[mem_addr[5:0] + 6'd1] = mem_wdata[15:8];
      mem[mem_addr[5:0] + 6'd2] = mem_wdata[23:16];
      mem[mem_addr[5:0] + 6'd3] = mem_wdata[31:24];
    end
    if (mem_rd)
      mem_rdata <= {mem[mem_addr[5:0] + 6'd3], mem[mem_addr[5:0] + 6'd2],
                    mem[mem_addr[5:0] + 6'd1], mem[mem_addr[5:0]]};
  end

  always @(negedge clk) begin
    if (mem_wr) begin
      wr_cnt++;
      last_wdata = mem_wdata;
      last_waddr = mem_addr;
    end
    if (mem_wr && mem_rd) overlap++;
    if (mem_rd && !rd_prev) rd_starts++;
    rd_prev = mem_rd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // Issues one request, returns cycles from accept (cycle 0) to done, 0 on timeout.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e);
    @(posedge clk); #1;
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        e = err_o;
        break;
      end
    end
  endtask

  int          lat, w0, r0;
  logic        e;
  logic [31:0] rdata_before;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem_rdata = '0;
    req = 0; we = 0; uns = 0; size = 0; addr = 0; wdata = 0;
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_wr", 32'(mem_wr), 0);
    check("rst_rd", 32'(mem_rd), 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    #19 rst_i = 1'b1;

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 32'h04, 32'hDEADBEEF, lat, e);
    check("st_word_lat", 32'(lat), 2);
    check("st_word_mem", mem_word(4), 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, lat, e);
    check("ld_word_lat", 32'(lat), 3);
    check("ld_word_data", rdata, 32'hDEADBEEF);

    // Byte store via read-modify-write
    mem[8] = 8'h44; mem[9] = 8'h33; mem[10] = 8'h22; mem[11] = 8'h11;
    w0 = wr_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h08, 32'h000000AA, lat, e);
    check("rmw_lat", 32'(lat), 3);
    check("rmw_wr_count", 32'(wr_cnt - w0), 1);
    check("rmw_wdata", last_wdata, 32'h112233AA);
    check("rmw_waddr", last_waddr, 32'h08);
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, e);
    check("rmw_readback", rdata, 32'h112233AA);

    // Sign / zero extension
    mem[16] = 8'h80;
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, e);
    check("ld_byte_s_lat", 32'(lat), 3);
    check("ld_byte_s", rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat, e);
    check("ld_byte_u", rdata, 32'h00000080);
    mem[16] = 8'h01; mem[17] = 8'h80;
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, e);
    check("ld_half_s", rdata, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, e);
    check("ld_half_u", rdata, 32'h00008001);

    // Unaligned word load at 0x06 spans bytes 0x06..0x09
    rdata_before = rdata;
    r0 = rd_starts;
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, e);
`ifdef MEM_ACC_ALIGN_CHK_EN
    check("misalign_lat", 32'(lat), 1);
    check("misalign_err", 32'(e), 1);
    check("misalign_no_rd", 32'(rd_starts - r0), 0);
    check("misalign_rdata", rdata, rdata_before);
`else
    check("unaligned_lat", 32'(lat), 3);
    check("unaligned_err", 32'(e), 0);
    check("unaligned_data", rdata, 32'h33AADEAD);
`endif

    // Held request with changing address: one access per accept
    mem[20] = 8'h88; mem[21] = 8'h77; mem[22] = 8'h66; mem[23] = 8'h55;
    r0 = rd_starts;
    @(posedge clk); #1;
    we = 1'b0; size = 2'b10; uns = 1'b0;
    for (int k = 0; k < 6; k++) begin
      req  = (k < 5);
      addr = 32'h04 + 32'(4 * k);
      @(negedge clk);
      case (k)
        0: check("hold_c0_busy", 32'(busy), 0);
        1: begin
          check("hold_c1_busy", 32'(busy), 1);
          check("hold_c1_addr", mem_addr, 32'h04);
        end
        2: check("hold_c2_busy", 32'(busy), 1);
        3: begin
          check("hold_c3_done", 32'(done), 1);
          check("hold_c3_busy", 32'(busy), 0);
          check("hold_c3_rdata", rdata, 32'hDEADBEEF);
        end
        4: begin
          check("hold_c4_busy", 32'(busy), 0);
          check("hold_c4_done", 32'(done), 0);
        end
        default: begin
          check("hold_c5_busy", 32'(busy), 1);
          check("hold_c5_addr", mem_addr, 32'h14);
        end
      endcase
      @(posedge clk); #1;
    end
    req = 1'b0;
    lat = 0;
    for (int i = 6; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    check("hold_second_done_cycle", 32'(lat), 7);
    check("hold_second_rdata", rdata, 32'h55667788);
    check("hold_rd_accesses", 32'(rd_starts - r0), 2);

    // Reset during RD_WAIT of a half store: no write may happen
    mem[32] = 8'hBE; mem[33] = 8'hBA; mem[34] = 8'hFE; mem[35] = 8'hCA;
    w0 = wr_cnt;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; size = 2'b01; uns = 1'b0; addr = 32'h20; wdata = 32'h00001234;
    @(posedge clk); #1;
    req = 1'b0;
    check("mid_rd_active", 32'(mem_rd), 1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_wr", 32'(mem_wr), 0);
    check("mid_rst_rd", 32'(mem_rd), 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    repeat (2) @(posedge clk);
    #2 rst_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_write", 32'(wr_cnt - w0), 0);
    check("mid_rst_mem", mem_word(32), 32'hCAFEBABE);
    check("mid_rst_idle", 32'(busy), 0);

    check("wr_rd_overlap", 32'(overlap), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
